// File: rtl/sram2uart_fifo.sv
// sram2uart_fifo: halfword-to-byte unpacking FIFO for the SRAM->UART readback path.
// Halfwords are pushed whole. They are popped one byte at a time, high byte first.
// data_out is first-word-fall-through: it shows the head byte without a pop.
// Single clock domain. Synchronous active-high reset.
module sram2uart_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       data_in,
    input  logic              en_write,
    output logic [7:0]        data_out,
    input  logic              en_read,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W+1:0] data_cnt,
    output logic              overflow,
    output logic              underflow
);

    localparam int               DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]  DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [ADDR_W:0]   word_cnt;
    logic              rd_half;   // 0: high byte is next, 1: low byte is next

    logic pop;
    logic push;
    logic free_now;

    // Status flags are derived purely from the registered state.
    assign empty    = (word_cnt == '0);
    assign full     = (word_cnt == DEPTH_W);
    assign data_cnt = {word_cnt, 1'b0} - {{(ADDR_W + 1){1'b0}}, rd_half};

    // Handshake qualification. A full FIFO can still take a push in the same
    // cycle that the head entry is released by its second byte pop.
    assign pop      = en_read & ~empty;
    assign free_now = pop & rd_half;
    assign push     = en_write & (~full | free_now);

    // Head byte selection. This path does not bypass data_in into data_out.
    always_comb begin
        // NOTE: give every always_comb output a default before any branch.
        // Otherwise a missed path infers a latch.
        data_out = 8'h00;
        if (!empty) begin
            data_out = rd_half ? mem[head][7:0] : mem[head][15:8];
        end
    end

    // Storage write. Contents are qualified by word_cnt, so stale words are never observed.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset on purpose. That keeps it a plain RAM.
        if (!rst && push) begin
            mem[tail] <= data_in;
        end
    end

    // Pointer, occupancy, byte-phase and sticky error flag update.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) only. Every register then
        // samples pre-edge values.
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            word_cnt  <= '0;
            rd_half   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_half <= ~rd_half;
                if (rd_half) begin
                    head <= head + 1'b1;
                end
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            case ({push, free_now})
                2'b10:   word_cnt <= word_cnt + 1'b1;
                2'b01:   word_cnt <= word_cnt - 1'b1;
                default: word_cnt <= word_cnt;
            endcase
            if (en_write && !push) begin
                overflow <= 1'b1;
            end
            if (en_read && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram2uart_fifo.sv
// tb_sram2uart_fifo: self-checking bench for sram2uart_fifo.
// Part 1 applies a table of directed vectors, each with its expected outputs.
// Part 2 runs hand-written corner sequences and a randomized stream. Both are
// checked against a byte-queue reference model.
module tb_sram2uart_fifo;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       data_in;
    logic              en_write;
    logic [7:0]        data_out;
    logic              en_read;
    logic              empty;
    logic              full;
    logic [ADDR_W+1:0] data_cnt;
    logic              overflow;
    logic              underflow;

    int n_checks = 0;
    int n_fail   = 0;

    sram2uart_fifo #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .en_write  (en_write),
        .data_out  (data_out),
        .en_read   (en_read),
        .empty     (empty),
        .full      (full),
        .data_cnt  (data_cnt),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Reference model. It stores the byte stream in send order.
    // A halfword occupies one entry until both of its bytes have left.
    logic [7:0] bq [$];
    bit         m_ovf;
    bit         m_udf;

    task automatic model_update(input bit r_st, input bit w, input bit rd, input logic [15:0] d);
        int  n;
        bit  do_pop;
        bit  frees;
        bit  do_push;
        if (r_st) begin
            bq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            n       = bq.size();
            do_pop  = rd && (n > 0);
            frees   = do_pop && (n % 2 == 1);
            do_push = w && (((n + 1) / 2 < DEPTH) || frees);
            if (do_pop) void'(bq.pop_front());
            if (do_push) begin
                bq.push_back(d[15:8]);
                bq.push_back(d[7:0]);
            end
            if (w && !do_push) m_ovf = 1'b1;
            if (rd && n == 0)  m_udf = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock the DUT, then compare every output
    // against the model. Sampling happens 1 time unit after the edge.
    task automatic step(input bit r_st, input bit w, input bit rd, input logic [15:0] d,
                        input string tag);
        int n;
        rst      = r_st;
        en_write = w;
        en_read  = rd;
        data_in  = d;
        model_update(r_st, w, rd, d);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        en_write = 1'b0;
        en_read  = 1'b0;
        n = bq.size();
        check({tag, ".data_out"},  32'(data_out),  (n > 0) ? 32'(bq[0]) : 32'h0);
        check({tag, ".empty"},     32'(empty),     32'(n == 0));
        check({tag, ".full"},      32'(full),      32'((n + 1) / 2 == DEPTH));
        check({tag, ".data_cnt"},  32'(data_cnt),  32'(n));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    typedef struct {
        bit          rst;
        bit          w;
        bit          r;
        logic [15:0] d;
        logic [7:0]  dout;
        bit          empty;
        bit          full;
        logic [5:0]  cnt;
        bit          ovf;
        bit          udf;
    } vec_t;

    initial begin
        vec_t vecs [$];
        int   pushed;
        int   popped;
        logic [7:0] exp_b;

        rst      = 1'b1;
        en_write = 1'b0;
        en_read  = 1'b0;
        data_in  = 16'h0;

        // Directed vectors: reset, then a two-halfword round trip, then an empty pop.
        //                 rst w  r  data      dout   emp  full cnt ovf udf
        vecs.push_back('{1, 0, 0, 16'h0000, 8'h00, 1, 0, 6'd0, 0, 0});
        vecs.push_back('{1, 0, 0, 16'h0000, 8'h00, 1, 0, 6'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 16'h21FF, 8'h21, 0, 0, 6'd2, 0, 0});
        vecs.push_back('{0, 1, 0, 16'hA55A, 8'h21, 0, 0, 6'd4, 0, 0});
        vecs.push_back('{0, 0, 1, 16'h0000, 8'hFF, 0, 0, 6'd3, 0, 0});
        vecs.push_back('{0, 0, 1, 16'h0000, 8'hA5, 0, 0, 6'd2, 0, 0});
        vecs.push_back('{0, 0, 1, 16'h0000, 8'h5A, 0, 0, 6'd1, 0, 0});
        vecs.push_back('{0, 0, 1, 16'h0000, 8'h00, 1, 0, 6'd0, 0, 0});
        vecs.push_back('{0, 0, 1, 16'h0000, 8'h00, 1, 0, 6'd0, 0, 1});
        vecs.push_back('{1, 0, 0, 16'h0000, 8'h00, 1, 0, 6'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 16'h1234, 8'h12, 0, 0, 6'd2, 0, 0});
        vecs.push_back('{0, 1, 1, 16'h5678, 8'h34, 0, 0, 6'd3, 0, 0});
        vecs.push_back('{0, 0, 1, 16'h0000, 8'h56, 0, 0, 6'd2, 0, 0});
        vecs.push_back('{1, 1, 1, 16'h9999, 8'h00, 1, 0, 6'd0, 0, 0});

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag      = $sformatf("vec%0d", i);
            rst      = vecs[i].rst;
            en_write = vecs[i].w;
            en_read  = vecs[i].r;
            data_in  = vecs[i].d;
            model_update(vecs[i].rst, vecs[i].w, vecs[i].r, vecs[i].d);
            @(posedge clk);
            #1;
            check({tag, ".data_out"},  32'(data_out),  32'(vecs[i].dout));
            check({tag, ".empty"},     32'(empty),     32'(vecs[i].empty));
            check({tag, ".full"},      32'(full),      32'(vecs[i].full));
            check({tag, ".data_cnt"},  32'(data_cnt),  32'(vecs[i].cnt));
            check({tag, ".overflow"},  32'(overflow),  32'(vecs[i].ovf));
            check({tag, ".underflow"}, 32'(underflow), 32'(vecs[i].udf));
        end
        rst      = 1'b0;
        en_write = 1'b0;
        en_read  = 1'b0;

        // Fill to capacity, drop a 17th push, then drain all 32 bytes in order.
        step(1, 0, 0, 16'h0, "fill.rst");
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 16'h0100 + 16'(i), $sformatf("fill.push%0d", i));
        check("fill.full_now", 32'(full), 32'h1);
        check("fill.cnt32",    32'(data_cnt), 32'd32);
        step(0, 1, 0, 16'hDEAD, "fill.push16");
        check("fill.ovf_set",  32'(overflow), 32'h1);
        for (int k = 0; k < 2 * DEPTH; k++) begin
            exp_b = (k % 2 == 0) ? 8'h01 : 8'(k / 2);
            check($sformatf("drain.byte%0d", k), 32'(data_out), 32'(exp_b));
            step(0, 0, 1, 16'h0, $sformatf("drain.pop%0d", k));
        end

        // Full with rd_half=1: a simultaneous push is accepted. With rd_half=0 it is dropped.
        step(1, 0, 0, 16'h0, "sim.rst");
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 16'h3000 + 16'(i), $sformatf("sim.push%0d", i));
        step(0, 0, 1, 16'h0, "sim.pop_hi");
        step(0, 1, 1, 16'hC0DE, "sim.wr_free");
        check("sim.accept_ovf",  32'(overflow), 32'h0);
        check("sim.accept_full", 32'(full),     32'h1);
        step(0, 1, 1, 16'hF00D, "sim.wr_nofree");
        check("sim.drop_ovf",    32'(overflow), 32'h1);

        // Stream 40 halfwords with interleaved traffic so both pointers wrap twice.
        step(1, 0, 0, 16'h0, "wrap.rst");
        pushed = 0;
        popped = 0;
        for (int c = 0; c < 2000 && popped < 80; c++) begin
            bit w;
            bit r;
            w = (pushed < 40) && ((bq.size() + 1) / 2 < DEPTH) && ($urandom_range(0, 3) != 0);
            r = (bq.size() > 0) && ($urandom_range(0, 2) != 0);
            step(0, w, r, 16'($urandom), $sformatf("wrap.c%0d", c));
            if (w) pushed++;
            if (r) popped++;
        end
        check("wrap.bytes_out", 32'(popped),    32'd80);
        check("wrap.no_ovf",    32'(overflow),  32'h0);
        check("wrap.no_udf",    32'(underflow), 32'h0);

        // Underflow is sticky. A mid-halfword reset clears everything.
        step(1, 0, 0, 16'h0, "udf.rst");
        step(0, 0, 1, 16'h0, "udf.pop_empty");
        check("udf.set", 32'(underflow), 32'h1);
        step(0, 1, 0, 16'h1122, "mid.push0");
        step(0, 1, 0, 16'h3344, "mid.push1");
        step(0, 0, 1, 16'h0, "mid.pop0");
        step(0, 0, 1, 16'h0, "mid.pop1");
        step(0, 0, 1, 16'h0, "mid.pop2");
        step(1, 0, 0, 16'h0, "mid.rst");
        check("mid.cleared_cnt", 32'(data_cnt), 32'd0);
        step(0, 1, 0, 16'hBEEF, "mid.push_beef");
        check("mid.be", 32'(data_out), 32'hBE);
        step(0, 0, 1, 16'h0, "mid.pop_be");
        check("mid.ef", 32'(data_out), 32'hEF);
        step(0, 0, 1, 16'h0, "mid.pop_ef");

        // Unconstrained random traffic, including overflow and underflow attempts.
        step(1, 0, 0, 16'h0, "rnd.rst");
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) < 5), 16'($urandom), $sformatf("rnd.c%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
